// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the parametrised SAR ADC controller.
// Holds the FSM state encoding, default sizing and the minimum frame length helper.
package sar_adc_pkg;

  localparam int DEF_NBIT     = 12;
  localparam int DEF_CNT_W    = 12;
  localparam int DEF_SAMP_CYC = 14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    CONV   = 3'd2,
    DONE   = 3'd3,
    WAIT   = 3'd4
  } state_t;

  // Shortest frame: sampling, one cycle per bit, one DONE cycle and one WAIT cycle.
  function automatic int min_period(input int samp_cyc, input int nbit);
    return samp_cyc + nbit + 2;
  endfunction

endpackage

// File: rtl/sar_adc_sar_reg.sv
// Successive-approximation trial/result register with a bit pointer.
// load_msb starts a search; each step resolves the pointed bit and sets the next one.
module sar_adc_sar_reg #(
  parameter int NBIT = 12
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            clr,
  input  logic            load_msb,
  input  logic            step,
  input  logic            comp,
  output logic [NBIT-1:0] code,
  output logic            last
);

  localparam int              PTR_W      = $clog2(NBIT);
  localparam logic [PTR_W-1:0] MSB_PTR_C  = PTR_W'(NBIT - 1);
  localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO_C = {PTR_W{1'b0}};
  localparam logic [NBIT-1:0]  MSB_CODE_C = {1'b1, {(NBIT-1){1'b0}}};

  logic [NBIT-1:0]  code_r;
  logic [NBIT-1:0]  trial_s;
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_s;

  // Resolve the current trial bit and set the next lower one.
  always_comb begin
    trial_s        = code_r;
    trial_s[ptr_r] = code_r[ptr_r] & comp;
    if (ptr_r != PTR_ZERO_C) begin
      trial_s[ptr_r - PTR_ONE_C] = 1'b1;
      ptr_s                      = ptr_r - PTR_ONE_C;
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Code and pointer registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      code_r <= {NBIT{1'b0}};
      ptr_r  <= PTR_ZERO_C;
    end else if (clr) begin
      code_r <= {NBIT{1'b0}};
      ptr_r  <= PTR_ZERO_C;
    end else if (load_msb) begin
      code_r <= MSB_CODE_C;
      ptr_r  <= MSB_PTR_C;
    end else if (step) begin
      code_r <= trial_s;
      ptr_r  <= ptr_s;
    end else begin
      code_r <= code_r;
      ptr_r  <= ptr_r;
    end
  end

  assign code = code_r;
  assign last = (ptr_r == PTR_ZERO_C);

endmodule

// File: rtl/sar_adc_ctrl_nbit.sv
// SAR ADC frame controller: sample/convert timing, front-end reset pulse,
// SAR search driving the CDAC, and a registered result with data-ready strobe.
module sar_adc_ctrl_nbit
  import sar_adc_pkg::*;
#(
  parameter int NBIT     = DEF_NBIT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAMP_CYC = DEF_SAMP_CYC
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic [CNT_W-1:0] PERIOD,
  input  logic             COMP,
  output logic             SAMP_N,
  output logic             WP_RSTN,
  output logic [NBIT-1:0]  DAC_CODE,
  output logic [NBIT-1:0]  DOUT,
  output logic             DR,
  output logic             BUSY
);

  localparam int               MIN_PERIOD  = min_period(SAMP_CYC, NBIT);
  localparam logic [CNT_W-1:0] MIN_PER_C   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] SAMP_LAST_C = CNT_W'(SAMP_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C       = CNT_W'(2);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, per_r, per_s;
  logic             samp_n_r, samp_n_s, wp_rstn_r, wp_rstn_s;
  logic             dr_r, dr_s, busy_r, busy_s;
  logic [NBIT-1:0]  dout_r, dout_s, code_s;
  logic             last_s, start_s, clr_s, load_msb_s, step_s;
  logic             samp_end_s, frame_end_s, arm_s;

  assign samp_end_s  = (cnt_r == SAMP_LAST_C);
  assign frame_end_s = (cnt_r == per_r - ONE_C);
  // The restart is committed one cycle early so WP_RSTN can be a registered pulse.
  assign arm_s       = EN && (cnt_r == per_r - TWO_C);

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a low WP_RSTN means the next frame is already committed.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (!wp_rstn_r) state_s = SAMPLE; else state_s = IDLE;
      SAMPLE:  if (samp_end_s) state_s = CONV;   else state_s = SAMPLE;
      CONV:    if (last_s)     state_s = DONE;   else state_s = CONV;
      DONE:    state_s = WAIT;
      WAIT: begin
        if (frame_end_s) begin
          if (!wp_rstn_r) state_s = SAMPLE; else state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and latched period.
  always_comb begin
    start_s    = (state_s == SAMPLE) && (state_r != SAMPLE);
    clr_s      = start_s || ((state_s == IDLE) && (state_r != IDLE));
    load_msb_s = (state_r == SAMPLE) && samp_end_s;
    step_s     = (state_r == CONV);
    samp_n_s   = (state_s != SAMPLE);
    busy_s     = (state_s != IDLE);
    dr_s       = step_s && last_s;
    if (dr_s) dout_s = {code_s[NBIT-1:1], COMP}; else dout_s = dout_r;
    if (start_s) per_s = (PERIOD < MIN_PER_C) ? MIN_PER_C : PERIOD; else per_s = per_r;
    if (start_s || !busy_s) cnt_s = {CNT_W{1'b0}}; else cnt_s = cnt_r + ONE_C;
    case (state_r)
      IDLE:       wp_rstn_s = !(EN && wp_rstn_r);
      DONE, WAIT: wp_rstn_s = !arm_s;
      default:    wp_rstn_s = 1'b1;
    endcase
  end

  // Output, counter and period registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_r     <= {CNT_W{1'b0}};
      per_r     <= MIN_PER_C;
      samp_n_r  <= 1'b1;
      wp_rstn_r <= 1'b1;
      dr_r      <= 1'b0;
      busy_r    <= 1'b0;
      dout_r    <= {NBIT{1'b0}};
    end else begin
      cnt_r     <= cnt_s;
      per_r     <= per_s;
      samp_n_r  <= samp_n_s;
      wp_rstn_r <= wp_rstn_s;
      dr_r      <= dr_s;
      busy_r    <= busy_s;
      dout_r    <= dout_s;
    end
  end

  sar_adc_sar_reg #(.NBIT(NBIT)) u_sar (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .clr      (clr_s),
    .load_msb (load_msb_s),
    .step     (step_s),
    .comp     (COMP),
    .code     (code_s),
    .last     (last_s)
  );

  assign SAMP_N   = samp_n_r;
  assign WP_RSTN  = wp_rstn_r;
  assign DAC_CODE = code_s;
  assign DOUT     = dout_r;
  assign DR       = dr_r;
  assign BUSY     = busy_r;

endmodule

// File: tb/tb_sar_adc_ctrl_nbit.sv
// Directed bench for sar_adc_ctrl_nbit: a 12-bit/14-cycle instance and an
// 8-bit/4-cycle instance, each driven by a behavioural comparator (Vin >= DAC).
module tb_sar_adc_ctrl_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, en_a, comp_a, samp_n_a, wp_a, dr_a, busy_a;
  logic [11:0] period_a, dac_a, dout_a, vin_a;
  logic [1:0]  mode_a;
  logic        rstn_b, en_b, comp_b, samp_n_b, wp_b, dr_b, busy_b;
  logic [11:0] period_b;
  logic [7:0]  dac_b, dout_b, vin_b;

  // mode 0 = comparator model, 1 = stuck high, 2 = stuck low
  assign comp_a = (mode_a == 2'd0) ? (vin_a >= dac_a) : (mode_a == 2'd1);
  assign comp_b = (vin_b >= dac_b);

  sar_adc_ctrl_nbit #(.NBIT(12), .CNT_W(12), .SAMP_CYC(14)) dut_a (
    .CLK(clk), .RSTN(rstn_a), .EN(en_a), .PERIOD(period_a), .COMP(comp_a),
    .SAMP_N(samp_n_a), .WP_RSTN(wp_a), .DAC_CODE(dac_a), .DOUT(dout_a),
    .DR(dr_a), .BUSY(busy_a)
  );

  sar_adc_ctrl_nbit #(.NBIT(8), .CNT_W(12), .SAMP_CYC(4)) dut_b (
    .CLK(clk), .RSTN(rstn_b), .EN(en_b), .PERIOD(period_b), .COMP(comp_b),
    .SAMP_N(samp_n_b), .WP_RSTN(wp_b), .DAC_CODE(dac_b), .DOUT(dout_b),
    .DR(dr_b), .BUSY(busy_b)
  );

  logic        sel;
  logic        mon_samp_n, mon_wp, mon_dr, mon_busy;
  logic [15:0] mon_dac, mon_dout;
  always_comb begin
    mon_samp_n = sel ? samp_n_b : samp_n_a;
    mon_wp     = sel ? wp_b     : wp_a;
    mon_dr     = sel ? dr_b     : dr_a;
    mon_busy   = sel ? busy_b   : busy_a;
    mon_dac    = sel ? {8'h00, dac_b}  : {4'h0, dac_a};
    mon_dout   = sel ? {8'h00, dout_b} : {4'h0, dout_a};
  end

  int          checks   = 0;
  int          failures = 0;
  int          samp_low, dr_at, dr_cnt, wp_at, busy_fall, len, start_k;
  logic [15:0] dout_dr;
  logic [15:0] dac_hist [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_samp_n"}, {31'd0, mon_samp_n}, 32'd1);
    chk({tag, "_wp_rstn"}, {31'd0, mon_wp}, 32'd1);
    chk({tag, "_dac"}, {16'd0, mon_dac}, 32'd0);
    chk({tag, "_dout"}, {16'd0, mon_dout}, 32'd0);
    chk({tag, "_dr"}, {31'd0, mon_dr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, mon_busy}, 32'd0);
  endtask

  // Called right after EN goes high in IDLE: one cycle of WP_RSTN low, then SAMPLE.
  task automatic wait_start(input string tag);
    logic prev_wp;
    start_k = 0;
    prev_wp = mon_wp;
    while (mon_samp_n !== 1'b0 && start_k < 10) begin
      prev_wp = mon_wp;
      @(negedge clk);
      start_k++;
    end
    chk({tag, "_start_edges"}, start_k, 32'd2);
    chk({tag, "_wp_before_sample"}, {31'd0, prev_wp}, 32'd0);
    chk({tag, "_busy_in_sample"}, {31'd0, mon_busy}, 32'd1);
  endtask

  // Observe one frame from its cnt=0 cycle; n counts cycles from frame start.
  task automatic run_frame(input int limit, input int act_at, input int act_kind);
    int   n;
    logic prev;
    samp_low = 0; dr_at = -1; dr_cnt = 0; wp_at = -1; busy_fall = -1; len = -1;
    dout_dr = 16'h0000;
    prev = 1'b0;
    n = 0;
    while (n < limit) begin
      if (n > 0 && mon_samp_n == 1'b0 && prev == 1'b1) begin
        len = n;
        break;
      end
      if (mon_samp_n == 1'b0 && n == samp_low) samp_low++;
      if (n < 64) dac_hist[n] = mon_dac;
      if (mon_dr) begin
        dr_cnt++;
        if (dr_at < 0) begin
          dr_at   = n;
          dout_dr = mon_dout;
        end
      end
      if (!mon_wp && wp_at < 0) wp_at = n;
      if (!mon_busy && busy_fall < 0) busy_fall = n;
      if (n == act_at && act_kind == 1) period_a = 12'd160;
      if (n == act_at && act_kind == 2) en_a = 1'b0;
      prev = mon_samp_n;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    sel = 1'b0;
    rstn_a = 1'b0; en_a = 1'b0; period_a = 12'd80; mode_a = 2'd0; vin_a = 12'hA5C;
    rstn_b = 1'b0; en_b = 1'b0; period_b = 12'd10; vin_b = 8'h5A;
    repeat (3) @(negedge clk);
    chk_reset("rst_a");

    rstn_a = 1'b1;
    @(negedge clk);
    chk("idle_no_en_samp_n", {31'd0, mon_samp_n}, 32'd1);
    chk("idle_no_en_busy", {31'd0, mon_busy}, 32'd0);
    en_a = 1'b1;
    wait_start("f1");

    // Frame 1: Vin=0xA5C, PERIOD=80
    run_frame(300, -1, 0);
    chk("f1_samp_low", samp_low, 32'd14);
    chk("f1_dac0", {16'd0, dac_hist[14]}, 32'h800);
    chk("f1_dac1", {16'd0, dac_hist[15]}, 32'hC00);
    chk("f1_dac2", {16'd0, dac_hist[16]}, 32'hA00);
    chk("f1_dr_latency", dr_at - samp_low + 1, 32'd13);
    chk("f1_dr_width", dr_cnt, 32'd1);
    chk("f1_dout", {16'd0, dout_dr}, 32'hA5C);
    chk("f1_dac_hold", {16'd0, dac_hist[40]}, 32'hA5C);
    chk("f1_wp_at", wp_at, 32'd79);
    chk("f1_len", len, 32'd80);
    chk("f1_restart_dac", {16'd0, mon_dac}, 32'd0);

    mode_a = 2'd1;
    run_frame(300, -1, 0);
    chk("stuck1_dout", {16'd0, dout_dr}, 32'hFFF);
    chk("stuck1_len", len, 32'd80);

    mode_a = 2'd2;
    run_frame(300, -1, 0);
    chk("stuck0_dr", dr_cnt, 32'd1);
    chk("stuck0_dout", {16'd0, dout_dr}, 32'h000);

    // PERIOD=10 written after this frame latched 80
    mode_a = 2'd0; vin_a = 12'h800; period_a = 12'd10;
    run_frame(300, -1, 0);
    chk("vin800_dout", {16'd0, dout_dr}, 32'h800);
    chk("vin800_len", len, 32'd80);

    period_a = 12'd80; vin_a = 12'h5A5;
    run_frame(300, -1, 0);
    chk("clamp_len", len, 32'd28);
    chk("clamp_wp_at", wp_at, 32'd27);
    chk("clamp_dout", {16'd0, dout_dr}, 32'h5A5);

    vin_a = 12'h3C3;
    run_frame(300, 40, 1);
    chk("permid_len", len, 32'd80);
    chk("permid_dout", {16'd0, dout_dr}, 32'h3C3);

    period_a = 12'd80; vin_a = 12'h1B7;
    run_frame(300, -1, 0);
    chk("per160_len", len, 32'd160);
    chk("per160_dout", {16'd0, dout_dr}, 32'h1B7);

    // EN dropped during CONV (cnt=20)
    vin_a = 12'h7E1;
    run_frame(200, 20, 2);
    chk("endrop_dr", dr_cnt, 32'd1);
    chk("endrop_dout", {16'd0, dout_dr}, 32'h7E1);
    chk("endrop_busy_fall", busy_fall, 32'd80);
    chk("endrop_no_restart", len, 32'hFFFF_FFFF);
    chk("endrop_no_wp", wp_at, 32'hFFFF_FFFF);
    chk("endrop_dout_hold", {16'd0, mon_dout}, 32'h7E1);
    chk("endrop_idle_dac", {16'd0, mon_dac}, 32'd0);

    en_a = 1'b1;
    wait_start("reen");

    // Reset asserted at cnt=20 (mid-CONV)
    vin_a = 12'h0F0;
    repeat (20) @(negedge clk);
    rstn_a = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rstn_a = 1'b1;
    wait_start("post_rst");
    run_frame(300, -1, 0);
    chk("post_rst_dout", {16'd0, dout_dr}, 32'h0F0);
    chk("post_rst_len", len, 32'd80);

    // 8-bit instance: SAMP_CYC=4, PERIOD=10 clamps to 14
    sel = 1'b1;
    #1;
    chk_reset("rst_b");
    @(negedge clk);
    rstn_b = 1'b1;
    en_b   = 1'b1;
    wait_start("b");
    run_frame(300, -1, 0);
    chk("b_samp_low", samp_low, 32'd4);
    chk("b_dac0", {16'd0, dac_hist[4]}, 32'h80);
    chk("b_dac1", {16'd0, dac_hist[5]}, 32'h40);
    chk("b_dac2", {16'd0, dac_hist[6]}, 32'h60);
    chk("b_dr_latency", dr_at - samp_low + 1, 32'd9);
    chk("b_dout", {16'd0, dout_dr}, 32'h5A);
    chk("b_wp_at", wp_at, 32'd13);
    chk("b_len", len, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
